// File: rtl/universal_reg_bank.sv
`default_nettype none
// ============================================================================
//  Module      : universal_reg_bank
//  Description : WIDTH-bit universal register with complementary outputs,
//                synchronous clear/preset, eight per-cycle modes (hold, load,
//                shift right/left, rotate right/left, increment, decrement)
//                and a multi-cycle serial-transmit burst with a
//                Start/Busy/Done handshake.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    CLK    in   1      clock, all state updates on the rising edge
//    Clr    in   1      synchronous active-high clear (highest priority)
//    Pre    in   1      synchronous active-high preset to PRE_VAL
//    En     in   1      enables the Mode operation (ignored during a burst)
//    Mode   in   3      operation select
//    D      in   WIDTH  parallel data for load and burst start
//    SI     in   1      serial input for shifts and burst fill
//    Start  in   1      request a serial-transmit burst of D
//    Q      out  WIDTH  register contents
//    Q_bar  out  WIDTH  ~Q
//    SO     out  1      serial output, Q[0]
//    TC     out  1      terminal count (combinational)
//    Busy   out  1      burst in progress
//    Done   out  1      one-cycle pulse at burst completion
// ============================================================================
module universal_reg_bank #(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] PRE_VAL = {WIDTH{1'b1}}
) (
  input  logic             CLK,
  input  logic             Clr,
  input  logic             Pre,
  input  logic             En,
  input  logic [2:0]       Mode,
  input  logic [WIDTH-1:0] D,
  input  logic             SI,
  input  logic             Start,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Q_bar,
  output logic             SO,
  output logic             TC,
  output logic             Busy,
  output logic             Done
);

  // Burst bit counter must reach WIDTH-1; keep at least one bit.
  localparam int               CNT_W    = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [WIDTH-1:0] Q_ONE    = WIDTH'(1);

  // Burst controller states
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_BURST = 1'b1;

  // Mode encodings
  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_LOAD = 3'b001;
  localparam logic [2:0] MODE_SHR  = 3'b010;
  localparam logic [2:0] MODE_SHL  = 3'b011;
  localparam logic [2:0] MODE_ROR  = 3'b100;
  localparam logic [2:0] MODE_ROL  = 3'b101;
  localparam logic [2:0] MODE_INC  = 3'b110;
  localparam logic [2:0] MODE_DEC  = 3'b111;

  logic [0:0]       state;
  logic [0:0]       state_next;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             done;
  logic             done_next;
  logic [WIDTH-1:0] mode_q;

  // --------------------------------------------------------------------------
  // State register. Clr has absolute priority and also aborts a burst
  // without producing a Done pulse.
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (Clr) begin
      state <= ST_IDLE;
      q     <= '0;
      cnt   <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      q     <= q_next;
      cnt   <= cnt_next;
      done  <= done_next;
    end
  end

  // --------------------------------------------------------------------------
  // Result of the selected Mode operation on the current contents.
  // --------------------------------------------------------------------------
  always_comb begin
    mode_q = q;
    case (Mode)
      MODE_HOLD: mode_q = q;
      MODE_LOAD: mode_q = D;
      MODE_SHR:  mode_q = {SI, q[WIDTH-1:1]};
      MODE_SHL:  mode_q = {q[WIDTH-2:0], SI};
      MODE_ROR:  mode_q = {q[0], q[WIDTH-1:1]};
      MODE_ROL:  mode_q = {q[WIDTH-2:0], q[WIDTH-1]};
      MODE_INC:  mode_q = q + Q_ONE;
      MODE_DEC:  mode_q = q - Q_ONE;
      default:   mode_q = q;
    endcase
  end

  // --------------------------------------------------------------------------
  // Next-state logic. Priority below Clr: Pre, active burst, Start, Mode.
  // Done is asserted only on the edge that retires the last burst bit, so it
  // defaults low every cycle.
  // --------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    q_next     = q;
    cnt_next   = cnt;
    done_next  = 1'b0;
    if (Pre) begin
      state_next = ST_IDLE;
      q_next     = PRE_VAL;
      cnt_next   = '0;
    end else begin
      case (state)
        ST_BURST: begin
          // Shift toward SO; En, Mode and Start are ignored here.
          q_next = {SI, q[WIDTH-1:1]};
          if (cnt == LAST_BIT) begin
            state_next = ST_IDLE;
            cnt_next   = '0;
            done_next  = 1'b1;
          end else begin
            cnt_next = cnt + CNT_ONE;
          end
        end
        ST_IDLE: begin
          // Start does not need En; a Start in the Done cycle is accepted
          // because the controller is already idle then.
          if (Start) begin
            state_next = ST_BURST;
            q_next     = D;
            cnt_next   = '0;
          end else if (En) begin
            q_next = mode_q;
          end
        end
        default: begin
          state_next = ST_IDLE;
          cnt_next   = '0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs. Q_bar and SO are pure functions of Q; TC looks only at Mode and
  // Q so it is independent of En and Busy.
  // --------------------------------------------------------------------------
  always_comb begin
    Q     = q;
    Q_bar = ~q;
    SO    = q[0];
    Busy  = (state == ST_BURST);
    Done  = done;
    TC    = ((Mode == MODE_INC) && (q == {WIDTH{1'b1}})) ||
            ((Mode == MODE_DEC) && (q == '0));
  end

endmodule
`default_nettype wire
